// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the bit-serial ALU sequencer:
//     - alu_ctrl codes {A_invert, B_invert, operation[1:0]}
//     - sequencer FSM state encoding
//     - small decode helpers used by the sequencer
//   No ports (package).
// ----------------------------------------------------------------------------
package alu_pkg;

    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_SLT = 4'b0111;
    localparam logic [3:0] CTRL_NOR = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } alu_state_t;

    // True for the bitwise operations (no carry chain involved).
    function automatic logic is_logic_op(input logic [3:0] ctrl);
        return (ctrl == CTRL_AND) || (ctrl == CTRL_OR) || (ctrl == CTRL_NOR);
    endfunction

    // True for any of the six recognised control codes.
    function automatic logic is_legal_op(input logic [3:0] ctrl);
        return is_logic_op(ctrl) || (ctrl == CTRL_ADD) ||
               (ctrl == CTRL_SUB) || (ctrl == CTRL_SLT);
    endfunction

endpackage

// File: rtl/alu_top.sv
// ----------------------------------------------------------------------------
// alu_top
//   Classic 1-bit ALU slice (AND / OR / full-adder / less pass-through) with
//   per-operand inversion.
//   Ports:
//     a, b        in   operand bits
//     a_invert    in   invert a before use
//     b_invert    in   invert b before use
//     carry_in    in   carry into this bit
//     less        in   value returned for operation 2'b11
//     operation   in   00=AND 01=OR 10=SUM 11=LESS
//     result      out  selected slice result
//     carry_out   out  full-adder carry out
// ----------------------------------------------------------------------------
module alu_top (
    input  logic       a,
    input  logic       b,
    input  logic       a_invert,
    input  logic       b_invert,
    input  logic       carry_in,
    input  logic       less,
    input  logic [1:0] operation,
    output logic       result,
    output logic       carry_out
);

    logic a_eff;
    logic b_eff;
    logic sum;

    assign a_eff     = a ^ a_invert;
    assign b_eff     = b ^ b_invert;
    assign sum       = a_eff ^ b_eff ^ carry_in;
    assign carry_out = (a_eff & b_eff) | (a_eff & carry_in) | (b_eff & carry_in);

    always_comb begin
        result = 1'b0;
        case (operation)
            2'b00:   result = a_eff & b_eff;
            2'b01:   result = a_eff | b_eff;
            2'b10:   result = sum;
            default: result = less;
        endcase
    end

endmodule

// File: rtl/alu_serial_seq.sv
// ----------------------------------------------------------------------------
// alu_serial_seq
//   Bit-serial WIDTH-bit ALU sequencer. Drives one alu_top slice LSB-first,
//   one bit per clock, with the slice carry held in a flop between bits.
//
//   Handshakes: a transfer happens on a rising clk edge where valid and ready
//   are both high. in_ready is high only in IDLE; out_valid is high only in
//   DONE, where result/zero/cout/overflow are held stable until out_ready.
//
//   Ports:
//     clk, rst           clock (rising edge), async active-high reset
//     in_valid/in_ready  operand handshake
//     src1, src2         operands A and B (WIDTH bits)
//     alu_ctrl           {A_invert, B_invert, operation[1:0]}
//     out_valid/out_ready result handshake
//     result             ALU result (WIDTH bits)
//     zero               result == 0
//     cout               carry out of MSB for ADD/SUB/SLT, else 0
//     overflow           signed overflow for ADD/SUB, else 0
//
//   Build option: define ALU_LOGIC_FASTPATH_EN to evaluate AND/OR/NOR in
//   parallel at acceptance and go straight to DONE.
// ----------------------------------------------------------------------------
module alu_serial_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic [3:0]       alu_ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    alu_state_t       state;
    logic [WIDTH-1:0] src1_q;       // shifted right each RUN cycle; bit 0 feeds the slice
    logic [WIDTH-1:0] src2_q;
    logic [3:0]       ctrl_q;
    logic             carry_q;
    logic [CNT_W-1:0] idx;

    logic [1:0]       op_drive;
    logic             slice_res;
    logic             slice_cout;

    logic             op_add;
    logic             op_sub;
    logic             op_slt;
    logic             ovf_raw;
    logic             set_bit;
    logic [WIDTH-1:0] res_shift;
    logic [WIDTH-1:0] final_res;
    logic             final_cout;
    logic             final_ovf;

    // SLT runs the slice as a plain subtract; the set bit is built afterwards.
    assign op_drive = (ctrl_q == CTRL_SLT) ? 2'b10 : ctrl_q[1:0];

    alu_top u_slice (
        .a         (src1_q[0]),
        .b         (src2_q[0]),
        .a_invert  (ctrl_q[3]),
        .b_invert  (ctrl_q[2]),
        .carry_in  (carry_q),
        .less      (1'b0),
        .operation (op_drive),
        .result    (slice_res),
        .carry_out (slice_cout)
    );

    assign op_add = (ctrl_q == CTRL_ADD);
    assign op_sub = (ctrl_q == CTRL_SUB);
    assign op_slt = (ctrl_q == CTRL_SLT);

    // Result bits enter at the MSB and move down, so after WIDTH shifts the
    // first (LSB) slice result has reached bit 0.
    assign res_shift = {slice_res, result[WIDTH-1:1]};

    // Only meaningful on the MSB cycle: carry_q is the carry into the MSB.
    assign ovf_raw = carry_q ^ slice_cout;
    assign set_bit = slice_res ^ ovf_raw;

    always_comb begin
        final_res  = res_shift;
        final_cout = 1'b0;
        final_ovf  = 1'b0;
        if (!is_legal_op(ctrl_q)) begin
            final_res = '0;
        end else if (op_slt) begin
            final_res  = {{(WIDTH-1){1'b0}}, set_bit};
            final_cout = slice_cout;
        end else if (op_add || op_sub) begin
            final_cout = slice_cout;
            final_ovf  = ovf_raw;
        end
    end

`ifdef ALU_LOGIC_FASTPATH_EN
    logic [WIDTH-1:0] fast_res;

    always_comb begin
        fast_res = '0;
        case (alu_ctrl)
            CTRL_AND: fast_res = src1 & src2;
            CTRL_OR:  fast_res = src1 | src2;
            CTRL_NOR: fast_res = ~(src1 | src2);
            default:  fast_res = '0;
        endcase
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
            src1_q    <= '0;
            src2_q    <= '0;
            ctrl_q    <= '0;
            carry_q   <= 1'b0;
            idx       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        src1_q   <= src1;
                        src2_q   <= src2;
                        ctrl_q   <= alu_ctrl;
                        carry_q  <= alu_ctrl[2];   // B_invert doubles as the +1 for subtract
                        idx      <= '0;
                        result   <= '0;
                        zero     <= 1'b0;
                        cout     <= 1'b0;
                        overflow <= 1'b0;
                        in_ready <= 1'b0;
`ifdef ALU_LOGIC_FASTPATH_EN
                        if (is_logic_op(alu_ctrl)) begin
                            result    <= fast_res;
                            zero      <= (fast_res == '0);
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= RUN;
                        end
`else
                        state <= RUN;
`endif
                    end
                end

                RUN: begin
                    src1_q  <= src1_q >> 1;
                    src2_q  <= src2_q >> 1;
                    carry_q <= slice_cout;
                    idx     <= idx + CNT_W'(1);
                    result  <= res_shift;
                    if (idx == LAST_IDX) begin
                        result    <= final_res;
                        zero      <= (final_res == '0);
                        cout      <= final_cout;
                        overflow  <= final_ovf;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial_seq.sv
// ----------------------------------------------------------------------------
// tb_alu_serial_seq
//   Directed and random checks of alu_serial_seq (WIDTH=32) against a
//   reference model written with plain integer arithmetic.
// ----------------------------------------------------------------------------
module tb_alu_serial_seq;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] src1;
  logic [W-1:0] src2;
  logic [3:0]   alu_ctrl;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         cout;
  logic         overflow;

  always #5 clk = ~clk;

  alu_serial_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .src1      (src1),
    .src2      (src2),
    .alu_ctrl  (alu_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .cout      (cout),
    .overflow  (overflow)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [W+2:0] exp_q[$];   // {result, zero, cout, overflow}

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference model: integer arithmetic on whole words.
  function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [3:0] c);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         co;
    logic         ov;
    r  = '0;
    co = 1'b0;
    ov = 1'b0;
    case (c)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b1100: r = ~(a | b);
      4'b0010: begin
        s  = {1'b0, a} + {1'b0, b};
        r  = s[W-1:0];
        co = s[W];
        ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      4'b0110: begin
        s  = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        r  = s[W-1:0];
        co = s[W];
        ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      4'b0111: begin
        s  = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        co = s[W];
        r  = ($signed(a) < $signed(b)) ? W'(1) : '0;
      end
      default: ;
    endcase
    return {r, (r == '0), co, ov};
  endfunction

  function automatic int exp_lat(input logic [3:0] c);
`ifdef ALU_LOGIC_FASTPATH_EN
    if (c == 4'b0000 || c == 4'b0001 || c == 4'b1100) return 1;
`endif
    return W + 1;
  endfunction

  // ---------------- driver tasks ----------------
  // One full transaction; latency counts the accept edge as cycle 1.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] c,
                        input int hold, input string tag);
    int n;
    int lat;
    logic [W+2:0] e;
    n = 0;
    while (in_ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, ":in_ready"}, 64'(n < 200), 64'(1));
    src1 = a; src2 = b; alu_ctrl = c; in_valid = 1'b1;
    exp_q.push_back(model(a, b, c));
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ":latency"}, 64'(lat), 64'(exp_lat(c)));
    e = exp_q.pop_front();
    check({tag, ":result"},   64'(result),   64'(e[W+2:3]));
    check({tag, ":zero"},     64'(zero),     64'(e[2]));
    check({tag, ":cout"},     64'(cout),     64'(e[1]));
    check({tag, ":overflow"}, 64'(overflow), 64'(e[0]));
    for (int i = 0; i < hold; i++) begin
      if (i == 1) begin
        in_valid = 1'b1; src1 = $urandom; src2 = $urandom; alu_ctrl = 4'b0010;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      check({tag, ":hold_valid"},  64'(out_valid), 64'(1));
      check({tag, ":hold_ready"},  64'(in_ready),  64'(0));
      check({tag, ":hold_result"}, 64'(result),    64'(e[W+2:3]));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ":post_valid"}, 64'(out_valid), 64'(0));
    check({tag, ":post_ready"}, 64'(in_ready),  64'(1));
  endtask

  // ---------------- stimulus ----------------
  logic [3:0] ctrl_tab [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110,
                               4'b0111, 4'b1100, 4'b0011, 4'b1111};

  initial begin
    int seen;
    int acc;
    int last;
    int got;
    logic [W+2:0] e;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    src1 = '0; src2 = '0; alu_ctrl = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  64'(in_ready),  64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_result",    64'(result),    64'(0));
    check("rst_flags",     64'({zero, cout, overflow}), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of RUN aborts the operation.
    src1 = 32'h1234_5678; src2 = 32'h0000_0001; alu_ctrl = 4'b0010; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_in_ready",  64'(in_ready),  64'(1));
    check("abort_out_valid", 64'(out_valid), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    check("abort_no_valid", 64'(seen), 64'(0));
    check("abort_ready",    64'(in_ready), 64'(1));

    // Directed operations.
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 4'b0010, 0, "add_ovf");
    run_op(32'h0000_0005, 32'h0000_0005, 4'b0110, 0, "sub_zero");
    run_op(32'h8000_0000, 32'h0000_0001, 4'b0110, 0, "sub_ovf");
    run_op(32'hFFFF_FFFD, 32'h0000_0002, 4'b0111, 0, "slt_neg");
    run_op(32'h0000_0002, 32'hFFFF_FFFD, 4'b0111, 0, "slt_pos");
    run_op(32'h8000_0000, 32'h7FFF_FFFF, 4'b0111, 0, "slt_ovf");
    run_op(32'h0F0F_0000, 32'h00F0_F0F0, 4'b1100, 0, "nor");
    run_op(32'hF0F0_1234, 32'h0FF0_FFFF, 4'b0000, 0, "and");
    run_op(32'hA5A5_0000, 32'h0000_5A5A, 4'b0001, 0, "or");
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 4'b0010, 0, "add_carry");
    run_op(32'h1234_5678, 32'h9ABC_DEF0, 4'b0011, 0, "illegal");
    run_op(32'hDEAD_BEEF, 32'h0000_0001, 4'b0010, 10, "backpressure");

    // Random operations.
    for (int i = 0; i < 24; i++) begin
      run_op($urandom, $urandom, ctrl_tab[$urandom_range(0, 7)],
             $urandom_range(0, 2), "random");
    end

    // Back-to-back with out_ready held high: one op per W+2 cycles.
    out_ready = 1'b1;
    acc = 0; last = 0; got = 0;
    for (int cyc = 0; cyc < 4 * (W + 2); cyc++) begin
      if (acc >= 3) begin
        in_valid = 1'b0;
      end else if (in_ready === 1'b1) begin
        src1 = $urandom; src2 = $urandom;
        alu_ctrl = ($urandom_range(0, 1) == 0) ? 4'b0010 : 4'b0110;
        in_valid = 1'b1;
        exp_q.push_back(model(src1, src2, alu_ctrl));
        if (acc > 0) check("tp_gap", 64'(cyc - last), 64'(W + 2));
        last = cyc;
        acc++;
      end
      if (out_valid === 1'b1) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("tp_result", 64'(result), 64'(e[W+2:3]));
          check("tp_flags",  64'({zero, cout, overflow}), 64'(e[2:0]));
        end
        got++;
      end
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("tp_count", 64'(got), 64'(3));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
